// File: rtl/led_p2s_driver.sv
// Serial LED chain driver: shifts P_Data MSB-first into a 74HC595-style chain, then pulses the latch.
// Define LED_P2S_AUTO_REFRESH_EN to also start a frame whenever P_Data differs from the last word sent.
module led_p2s_driver #(
  parameter int DATA_BITS = 16,
  parameter int CLK_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] P_Data,
  output logic                 s_clk,
  output logic                 s_clrn,
  output logic                 sout,
  output logic                 EN,
  output logic                 busy,
  output logic                 done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SHIFT_LO = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_LATCH    = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 s_clk_q, s_clk_d;
  logic                 s_clrn_q;
  logic                 sout_q, sout_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 go;
  logic                 div_last;

`ifdef LED_P2S_AUTO_REFRESH_EN
  logic [DATA_BITS-1:0] last_sent_q, last_sent_d;

  // A new GPIO value counts as a frame request, exactly like an external start.
  assign go = start | (P_Data != last_sent_q);
`else
  assign go = start;
`endif

  assign div_last = (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
`ifdef LED_P2S_AUTO_REFRESH_EN
    last_sent_d = last_sent_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d   = ST_SHIFT_LO;
          shreg_d   = P_Data;
          div_cnt_d = '0;
          bit_cnt_d = '0;
`ifdef LED_P2S_AUTO_REFRESH_EN
          last_sent_d = P_Data;
`endif
        end
      end
      ST_SHIFT_LO: begin
        if (div_last) begin
          div_cnt_d = '0;
          state_d   = ST_SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (div_last) begin
          div_cnt_d = '0;
          // Shift on the falling edge of s_clk so sout never moves while s_clk rises.
          shreg_d   = shreg_q << 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = ST_LATCH;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = ST_SHIFT_LO;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (div_last) begin
          div_cnt_d = '0;
          state_d   = ST_DONE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered decodes of the next state, so the chain sees glitch-free lines.
  always_comb begin
    s_clk_d = (state_d == ST_SHIFT_HI);
    en_d    = (state_d == ST_LATCH);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    sout_d  = 1'b0;
    if ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) begin
      sout_d = shreg_d[DATA_BITS-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      s_clk_q   <= 1'b0;
      s_clrn_q  <= 1'b0;
      sout_q    <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      s_clk_q   <= s_clk_d;
      s_clrn_q  <= 1'b1;
      sout_q    <= sout_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef LED_P2S_AUTO_REFRESH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      last_sent_q <= '0;
    end else begin
      last_sent_q <= last_sent_d;
    end
  end
`endif

  assign s_clk  = s_clk_q;
  assign s_clrn = s_clrn_q;
  assign sout   = sout_q;
  assign EN     = en_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
